// File: rtl/encoder_8to3_event.sv
// Edge-detecting 8-to-3 event encoder with pending bits and a 4-deep FIFO.
// Optional ENCODER_OVF_CNT_EN adds a saturating lost-event counter (ovf_cnt).
module encoder_8to3_event (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] x,
   input  logic       ready,
   output logic [2:0] y,
   output logic       valid,
   output logic       ovf
`ifdef ENCODER_OVF_CNT_EN
   ,
   output logic [7:0] ovf_cnt
`endif
);

   logic [7:0] x_q;
   logic [7:0] pend;
   logic [2:0] mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] cnt;

   logic [7:0] rise;
   logic       pop;
   logic       slot;
   logic       push;
   logic [2:0] idx;
   logic [7:0] pend_clr;
   logic [7:0] pend_next;
   logic       lost;
   logic [2:0] cnt_next;
   logic [1:0] rd_next;
   logic [2:0] y_next;

   always_comb begin
      rise = x & ~x_q;
      pop  = valid & ready;
      slot = (cnt != 3'd4) | pop;
      push = (|pend) & slot;
      idx  = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (pend[i]) idx = 3'(i);
      end
      pend_clr  = push ? (8'd1 << idx) : 8'd0;
      // a rise on a bit being cleared keeps it pending
      pend_next = (pend & ~pend_clr) | rise;
      lost      = |(rise & pend & ~pend_clr);
      cnt_next  = cnt + {2'b00, push} - {2'b00, pop};
      rd_next   = rd_ptr + {1'b0, pop};
      y_next    = 3'd0;
      if (cnt_next != 3'd0) begin
         if (push && (cnt == {2'b00, pop})) y_next = idx;
         else y_next = mem[rd_next];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q    <= 8'hFF;
         pend   <= 8'd0;
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         cnt    <= 3'd0;
         y      <= 3'd0;
         valid  <= 1'b0;
         ovf    <= 1'b0;
         for (int i = 0; i < 4; i++) mem[i] <= 3'd0;
      end else begin
         x_q    <= x;
         pend   <= pend_next;
         rd_ptr <= rd_next;
         cnt    <= cnt_next;
         y      <= y_next;
         valid  <= (cnt_next != 3'd0);
         ovf    <= lost;
         if (push) begin
            mem[wr_ptr] <= idx;
            wr_ptr      <= wr_ptr + 2'd1;
         end
      end
   end

`ifdef ENCODER_OVF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovf_cnt <= 8'd0;
      else if (lost && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_encoder_8to3_event.sv
// Directed bench for encoder_8to3_event: vector table plus
// hand-written backpressure, overflow and reset sequences.
module tb_encoder_8to3_event;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] x = 8'h00;
   logic       ready = 1'b0;
   logic [2:0] y;
   logic       valid;
   logic       ovf;
`ifdef ENCODER_OVF_CNT_EN
   logic [7:0] ovf_cnt;
`endif

   int total = 0;
   int bad = 0;

   encoder_8to3_event dut (
      .clk     (clk),
      .reset_n (reset_n),
      .x       (x),
      .ready   (ready),
      .y       (y),
      .valid   (valid),
      .ovf     (ovf)
`ifdef ENCODER_OVF_CNT_EN
      ,
      .ovf_cnt (ovf_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] x;
      logic       ready;
      logic [2:0] y;
      logic       valid;
      logic       ovf;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic chk_out(input string name, input logic v,
                          input logic [2:0] yy, input logic o);
      check({name, ".valid"}, {7'd0, valid}, {7'd0, v});
      check({name, ".y"}, {5'd0, y}, {5'd0, yy});
      check({name, ".ovf"}, {7'd0, ovf}, {7'd0, o});
   endtask

   logic [2:0] exp_seq [6];
   logic [2:0] ovf_seq [4];

   initial begin
      tbl[0] = '{8'h00, 1'b1, 3'd0, 1'b0, 1'b0};
      tbl[1] = '{8'h20, 1'b1, 3'd0, 1'b0, 1'b0};
      tbl[2] = '{8'h20, 1'b1, 3'd5, 1'b1, 1'b0};
      tbl[3] = '{8'h20, 1'b1, 3'd0, 1'b0, 1'b0};
      tbl[4] = '{8'h00, 1'b1, 3'd0, 1'b0, 1'b0};
      tbl[5] = '{8'h91, 1'b1, 3'd0, 1'b0, 1'b0};
      tbl[6] = '{8'h91, 1'b1, 3'd7, 1'b1, 1'b0};
      tbl[7] = '{8'h91, 1'b1, 3'd4, 1'b1, 1'b0};
      tbl[8] = '{8'h91, 1'b1, 3'd0, 1'b1, 1'b0};
      tbl[9] = '{8'h91, 1'b1, 3'd0, 1'b0, 1'b0};
      exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5};
      ovf_seq = '{3'd1, 3'd3, 3'd4, 3'd2};

      #2;
      chk_out("reset", 1'b0, 3'd0, 1'b0);
      do_reset();

      for (int i = 0; i < 10; i++) begin
         x = tbl[i].x;
         ready = tbl[i].ready;
         tick();
         chk_out($sformatf("vec%0d", i), tbl[i].valid, tbl[i].y, tbl[i].ovf);
      end

      // backpressure: six rises, four queued, two pending
      do_reset();
      ready = 1'b0;
      x = 8'h00;
      tick();
      x = 8'h02; tick();
      x = 8'h06; tick();
      x = 8'h0E; tick();
      x = 8'h1E; tick();
      x = 8'h3E; tick();
      x = 8'h7E; tick();
      chk_out("bp_hold0", 1'b1, 3'd1, 1'b0);
      tick();
      tick();
      chk_out("bp_hold1", 1'b1, 3'd1, 1'b0);
      ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk_out($sformatf("bp_del%0d", i), 1'b1, exp_seq[i], 1'b0);
         tick();
      end
      chk_out("bp_empty", 1'b0, 3'd0, 1'b0);

      // overflow: FIFO full, x[2] pulses twice
      do_reset();
      ready = 1'b0;
      x = 8'h00; tick();
      x = 8'h01; tick();
      x = 8'h03; tick();
      x = 8'h0B; tick();
      x = 8'h1B; tick();
      tick();
      chk_out("of_full", 1'b1, 3'd0, 1'b0);
      x = 8'h1F; tick();
      chk_out("of_rise1", 1'b1, 3'd0, 1'b0);
      x = 8'h1B; tick();
      chk_out("of_fall", 1'b1, 3'd0, 1'b0);
      x = 8'h1F; tick();
      chk_out("of_rise2", 1'b1, 3'd0, 1'b1);
      tick();
      chk_out("of_after", 1'b1, 3'd0, 1'b0);
`ifdef ENCODER_OVF_CNT_EN
      check("of_cnt", ovf_cnt, 8'd1);
`endif
      ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk_out($sformatf("of_del%0d", i), 1'b1, ovf_seq[i], 1'b0);
         tick();
      end
      chk_out("of_empty", 1'b0, 3'd0, 1'b0);

      // reset with lines held high
      x = 8'hFF;
      ready = 1'b1;
      do_reset();
      chk_out("rst_ff0", 1'b0, 3'd0, 1'b0);
      tick(); tick(); tick();
      chk_out("rst_ff1", 1'b0, 3'd0, 1'b0);

      // reset mid-operation with three events queued
      ready = 1'b0;
      x = 8'h00; tick();
      x = 8'h01; tick();
      x = 8'h03; tick();
      x = 8'h07; tick();
      tick();
      chk_out("rst_q3", 1'b1, 3'd0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_out("rst_async", 1'b0, 3'd0, 1'b0);
      tick();
      reset_n = 1'b1;
      tick(); tick(); tick();
      chk_out("rst_stale", 1'b0, 3'd0, 1'b0);
      x = 8'h00; tick();
      x = 8'h08; tick();
      chk_out("rst_new0", 1'b0, 3'd0, 1'b0);
      tick();
      chk_out("rst_new1", 1'b1, 3'd3, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/encoder_8to3_event.md
ENCODER_8TO3_EVENT -- requirements
Module: encoder_8to3_event

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-002 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port x, input, 8 bits: event lines, synchronous to clk; x[i] has index i.
REQ-005 Port y, output, 3 bits: binary index of the head event; registered.
REQ-006 Port valid, output, 1 bit: y holds an event; registered.
REQ-007 Port ready, input, 1 bit: consumer accepts; an event transfers on a clk edge where valid=1 and ready=1.
REQ-008 Port ovf, output, 1 bit: one-cycle pulse when an event is lost; registered.
REQ-009 Port ovf_cnt, output, 8 bits: lost-event count; present only with ENCODER_OVF_CNT_EN.

Function
REQ-010 The block SHALL register x into x_q every cycle; rise[i] = x[i] & ~x_q[i].
REQ-011 The block SHALL set pend[i] on the edge where rise[i]=1, independent of FIFO state.
REQ-012 When pend is nonzero and a FIFO slot is available, the block SHALL push the highest set pend index and clear that pend bit on the same edge; one push per cycle maximum.
REQ-013 A FIFO slot is available when occupancy < 4, or occupancy = 4 and a transfer occurs on the same edge.
REQ-014 If rise[i]=1 on the edge pend[i] is cleared by a push, pend[i] SHALL remain set (set wins).
REQ-015 If rise[i]=1 while pend[i] is already 1 and not being cleared, the event SHALL be lost: ovf=1 for exactly that following cycle.
REQ-016 Multiple lost events in one edge SHALL produce a single ovf pulse.
REQ-017 FIFO SHALL be 4 entries of 3 bits, first-in first-out; y/valid reflect the head entry.
REQ-018 Latency: x[i] rising before edge k gives pend[i]=1 after edge k, and valid=1, y=i after edge k+1, if the FIFO is empty.
REQ-019 Empty FIFO SHALL give valid=0 and y=0; y SHALL NOT change while valid=1 and ready=0.
REQ-020 Simultaneous push and transfer SHALL leave occupancy unchanged; pointers SHALL wrap modulo 4.
REQ-021 ready while valid=0 SHALL have no effect.

Reset
REQ-022 reset_n=0 SHALL asynchronously force y=0, valid=0, ovf=0, pend=0, FIFO occupancy=0, and ovf_cnt=0 when present.
REQ-023 reset_n=0 SHALL force x_q=8'hFF, so lines held high across reset release generate no event.
REQ-024 Reset asserted mid-operation SHALL discard all pending and queued events; the first event after release follows REQ-018.

Configuration
REQ-025 Macro ENCODER_OVF_CNT_EN defined: ovf_cnt SHALL increment by 1 on each ovf pulse, saturating at 255.
REQ-026 Macro ENCODER_OVF_CNT_EN undefined: ovf_cnt port and its counter SHALL be absent; ovf is unchanged.

Verification
REQ-027 Single event, ready=1: x=8'h00 then x[5] rises -> valid=1 and y=3'd5 two edges later, for one cycle, with ovf=0.
REQ-028 Simultaneous rises, ready=1: x 8'h00 -> 8'h91 -> y sequence 7, 4, 0 on consecutive cycles.
REQ-029 Backpressure, ready=0: 6 distinct single-bit rises -> 4 events queued; y holds the first; the remaining 2 stay pending; after ready=1 all 6 are delivered with no ovf.
REQ-030 Overflow, ready=0 and FIFO full: x[2] pulses twice -> one ovf pulse on the second rise; ovf_cnt=1 with ENCODER_OVF_CNT_EN.
REQ-031 Reset: x=8'hFF held through reset release -> valid stays 0; reset asserted with 3 events queued -> valid=0 immediately, with no stale events after release.
